// File: rtl/exec_core_if.sv
// Bus between the execute core and its external instruction memory,
// register file and data memory. The core is the master side.
interface exec_core_if #(
  parameter int PC_WIDTH = 16
) ();
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] pc;
  logic [4:0]          rf_raddr1;
  logic [4:0]          rf_raddr2;
  logic [31:0]         rf_rdata1;
  logic [31:0]         rf_rdata2;
  logic                rf_we;
  logic [4:0]          rf_waddr;
  logic [31:0]         rf_wdata;
  logic [31:0]         dmem_addr;
  logic                dmem_we;
  logic [31:0]         dmem_wdata;
  logic [31:0]         dmem_rdata;
  logic                alu_zero;

  modport master (
    input  instr, rf_rdata1, rf_rdata2, dmem_rdata,
    output pc, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
           dmem_addr, dmem_we, dmem_wdata, alu_zero
  );

  modport slave (
    output instr, rf_rdata1, rf_rdata2, dmem_rdata,
    input  pc, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
           dmem_addr, dmem_we, dmem_wdata, alu_zero
  );
endinterface

// File: rtl/exec_core.sv
// Single-cycle MIPS-style execute/control datapath. Decodes the current
// instruction, drives register-file and data-memory controls combinationally
// and holds the word-addressed program counter, its only state.
module exec_core #(
  parameter int PC_WIDTH = 16,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst,
  exec_core_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] simm, zimm;
  logic [31:0] op_a, op_b;

  assign opcode = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];
  assign shamt  = bus.instr[10:6];
  assign funct  = bus.instr[5:0];
  assign imm    = bus.instr[15:0];
  assign simm   = {{16{imm[15]}}, imm};
  assign zimm   = {16'h0000, imm};
  assign op_a   = bus.rf_rdata1;
  assign op_b   = bus.rf_rdata2;

  logic [31:0]         alu_res;
  logic                wr_en, mem_rd, mem_wr, is_beq, is_bne, is_j;
  logic [4:0]          waddr;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;

  // Instruction decode and ALU.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statements leaves a value held (no latch).
    alu_res = '0;
    wr_en   = 1'b0;
    waddr   = rt;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        waddr = rd;
        wr_en = 1'b1;
        case (funct)
          FN_ADD:  alu_res = op_a + op_b;
          FN_SUB:  alu_res = op_a - op_b;
          FN_AND:  alu_res = op_a & op_b;
          FN_OR:   alu_res = op_a | op_b;
          FN_SLL:  alu_res = op_b << shamt;
          FN_SRL:  alu_res = op_b >> shamt;
          FN_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
          default: wr_en   = 1'b0;
        endcase
      end
      OP_ADDI: begin alu_res = op_a + simm; wr_en = 1'b1; end
      OP_ANDI: begin alu_res = op_a & zimm; wr_en = 1'b1; end
      OP_ORI:  begin alu_res = op_a | zimm; wr_en = 1'b1; end
      OP_LW:   begin alu_res = op_a + simm; wr_en = 1'b1; mem_rd = 1'b1; end
      OP_SW:   begin alu_res = op_a + simm; mem_wr = 1'b1; end
      OP_BEQ:  begin alu_res = op_a - op_b; is_beq = 1'b1; end
      OP_BNE:  begin alu_res = op_a - op_b; is_bne = 1'b1; end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  // Register-file and data-memory controls; writes are squashed during reset
  // and register 0 is never written.
  assign bus.rf_raddr1  = rs;
  assign bus.rf_raddr2  = rt;
  assign bus.alu_zero   = (alu_res == 32'd0);
  assign bus.rf_waddr   = waddr;
  assign bus.rf_wdata   = mem_rd ? bus.dmem_rdata : alu_res;
  assign bus.rf_we      = wr_en && (waddr != 5'd0) && !rst;
  assign bus.dmem_addr  = (mem_rd || mem_wr) ? alu_res : 32'd0;
  assign bus.dmem_we    = mem_wr && !rst;
  assign bus.dmem_wdata = op_b;
  assign bus.pc         = pc_q;

  // Next-PC selection; all PC arithmetic wraps at PC_WIDTH bits.
  always_comb begin
    pc_inc = pc_q + PC_WIDTH'(1);
    pc_d   = pc_inc;
    if (is_j)
      pc_d = PC_WIDTH'(zimm);
    else if ((is_beq && bus.alu_zero) || (is_bne && !bus.alu_zero))
      pc_d = pc_inc + PC_WIDTH'(simm);
  end

  // Program counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) pc_q <= PC_WIDTH'(RESET_PC);
    else     pc_q <= pc_d;
  end

endmodule

// File: tb/tb_exec_core.sv
// Directed testbench for exec_core: a table of single-instruction vectors
// plus hand-written PC sequences for reset, branches, jump and wrap.
module tb_exec_core;

  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  exec_core_if #(.PC_WIDTH(PW)) bus ();

  exec_core #(.PC_WIDTH(PW), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [31:0] instr, rd1, rd2, dmr;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic        chk_wd;
    logic [31:0] exp_wdata;
    logic [31:0] exp_daddr;
    logic        exp_dwe;
    logic        chk_zero;
    logic        exp_zero;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic add_vec(input string name, input logic [31:0] instr, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] dmr, input logic we,
                         input logic [4:0] waddr, input logic chk_wd, input logic [31:0] wdata,
                         input logic [31:0] daddr, input logic dwe, input logic chk_zero,
                         input logic zero);
    vec_t v;
    v.name = name; v.instr = instr; v.rd1 = rd1; v.rd2 = rd2; v.dmr = dmr;
    v.exp_we = we; v.exp_waddr = waddr; v.chk_wd = chk_wd; v.exp_wdata = wdata;
    v.exp_daddr = daddr; v.exp_dwe = dwe; v.chk_zero = chk_zero; v.exp_zero = zero;
    vq.push_back(v);
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] dmr);
    bus.instr = instr; bus.rf_rdata1 = rd1; bus.rf_rdata2 = rd2; bus.dmem_rdata = dmr;
    #1;
  endtask

  // Execute one instruction and check the resulting PC.
  task automatic exec_pc(input string name, input logic [31:0] instr, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [PW-1:0] exp_pc);
    drive(instr, rd1, rd2, 32'h0);
    step();
    check(name, 32'(bus.pc), 32'(exp_pc));
  endtask

  logic [PW-1:0] pc_exp;
  logic [31:0]   add_r3 = 32'h0022_1820;  // add r3,r1,r2

  initial begin
    // name, instr, rd1, rd2, dmr, we, waddr, chk_wd, wdata, daddr, dwe, chk_zero, zero
    add_vec("add",     rtype(1,2,3,0,6'h20), 7, 5, 0, 1, 3, 1, 32'd12, 0, 0, 1, 0);
    add_vec("sub",     rtype(1,2,3,0,6'h22), 7, 5, 0, 1, 3, 1, 32'd2,  0, 0, 1, 0);
    add_vec("and",     rtype(1,2,3,0,6'h24), 7, 5, 0, 1, 3, 1, 32'd5,  0, 0, 1, 0);
    add_vec("or",      rtype(1,2,3,0,6'h25), 7, 5, 0, 1, 3, 1, 32'd7,  0, 0, 1, 0);
    add_vec("slt",     rtype(1,2,3,0,6'h2A), 7, 5, 0, 1, 3, 1, 32'd0,  0, 0, 1, 1);
    add_vec("sub_neg", rtype(1,2,9,0,6'h22), 5, 7, 0, 1, 9, 1, 32'hFFFF_FFFE, 0, 0, 1, 0);
    add_vec("slt_neg", rtype(1,2,9,0,6'h2A), 32'hFFFF_FFFF, 1, 0, 1, 9, 1, 32'd1, 0, 0, 1, 0);
    add_vec("sll31",   rtype(0,2,4,31,6'h00), 0, 1, 0, 1, 4, 1, 32'h8000_0000, 0, 0, 1, 0);
    add_vec("srl4",    rtype(0,2,4,4,6'h02), 0, 32'h8000_0000, 0, 1, 4, 1, 32'h0800_0000, 0, 0, 1, 0);
    add_vec("rd0",     rtype(1,2,0,0,6'h20), 7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec("bad_fn",  rtype(1,2,3,0,6'h3F), 7, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    add_vec("addi",    itype(6'h08,4,6,16'hFFFC), 100, 0, 0, 1, 6, 1, 32'd96, 0, 0, 1, 0);
    add_vec("andi",    itype(6'h0C,4,6,16'h8F0F), 32'hFFFF_00F0, 0, 0, 1, 6, 1, 32'd0, 0, 0, 1, 1);
    add_vec("ori",     itype(6'h0D,4,6,16'h8001), 32'hF000_0000, 0, 0, 1, 6, 1, 32'hF000_8001, 0, 0, 1, 0);
    add_vec("lw",      itype(6'h23,4,6,16'hFFFC), 100, 0, 32'hCAFE_BABE, 1, 6, 1, 32'hCAFE_BABE, 96, 0, 1, 0);
    add_vec("sw",      itype(6'h2B,4,6,16'hFFFC), 100, 32'h1234_5678, 0, 0, 6, 0, 0, 96, 1, 1, 0);
    add_vec("bad_op",  itype(6'h3F,4,6,16'h0001), 100, 5, 0, 0, 6, 0, 0, 0, 0, 0, 0);

    // Reset held two cycles with a writing instruction on the bus.
    rst = 1'b1;
    drive(add_r3, 7, 5, 0);
    check("rst_rf_we", 32'(bus.rf_we), 0);
    check("rst_dmem_we", 32'(bus.dmem_we), 0);
    step();
    step();
    check("rst_pc", 32'(bus.pc), 0);
    check("rst_rf_we_held", 32'(bus.rf_we), 0);
    drive(itype(6'h2B,4,6,16'h0000), 100, 5, 0);
    check("rst_dmem_we_sw", 32'(bus.dmem_we), 0);
    drive(add_r3, 7, 5, 0);
    rst = 1'b0;
    #1;
    check("rel_rf_we", 32'(bus.rf_we), 1);
    check("rel_pc0", 32'(bus.pc), 0);
    step();
    check("rel_pc1", 32'(bus.pc), 1);
    step();
    check("rel_pc2", 32'(bus.pc), 2);
    pc_exp = 16'd2;

    // Table-driven single-instruction vectors.
    foreach (vq[i]) begin
      drive(vq[i].instr, vq[i].rd1, vq[i].rd2, vq[i].dmr);
      check({vq[i].name, "_rf_we"}, 32'(bus.rf_we), 32'(vq[i].exp_we));
      check({vq[i].name, "_raddr1"}, 32'(bus.rf_raddr1), 32'(vq[i].instr[25:21]));
      check({vq[i].name, "_raddr2"}, 32'(bus.rf_raddr2), 32'(vq[i].instr[20:16]));
      if (vq[i].exp_we)
        check({vq[i].name, "_waddr"}, 32'(bus.rf_waddr), 32'(vq[i].exp_waddr));
      if (vq[i].chk_wd)
        check({vq[i].name, "_wdata"}, bus.rf_wdata, vq[i].exp_wdata);
      check({vq[i].name, "_daddr"}, bus.dmem_addr, vq[i].exp_daddr);
      check({vq[i].name, "_dwe"}, 32'(bus.dmem_we), 32'(vq[i].exp_dwe));
      check({vq[i].name, "_dwdata"}, bus.dmem_wdata, vq[i].rd2);
      if (vq[i].chk_zero)
        check({vq[i].name, "_zero"}, 32'(bus.alu_zero), 32'(vq[i].exp_zero));
      step();
      pc_exp = pc_exp + 16'd1;
      check({vq[i].name, "_pc"}, 32'(bus.pc), 32'(pc_exp));
    end

    // Branches from pc = 10.
    exec_pc("j10_a", itype(6'h02,0,0,16'd10), 0, 0, 16'd10);
    drive(itype(6'h04,1,2,16'd5), 3, 3, 0);
    check("beq_t_zero", 32'(bus.alu_zero), 1);
    check("beq_rf_we", 32'(bus.rf_we), 0);
    check("beq_daddr", bus.dmem_addr, 0);
    exec_pc("beq_taken", itype(6'h04,1,2,16'd5), 3, 3, 16'd16);
    exec_pc("j10_b", itype(6'h02,0,0,16'd10), 0, 0, 16'd10);
    exec_pc("beq_not", itype(6'h04,1,2,16'd5), 3, 4, 16'd11);
    exec_pc("j10_c", itype(6'h02,0,0,16'd10), 0, 0, 16'd10);
    exec_pc("bne_back", itype(6'h05,1,2,16'hFFFE), 3, 4, 16'd9);
    exec_pc("bne_not", itype(6'h05,1,2,16'hFFFE), 4, 4, 16'd10);

    // Jump, wrap, unknown opcode.
    exec_pc("j64", itype(6'h02,0,0,16'h0040), 0, 0, 16'd64);
    exec_pc("j_ffff", itype(6'h02,0,0,16'hFFFF), 0, 0, 16'hFFFF);
    drive(itype(6'h3F,1,2,16'h1234), 9, 9, 0);
    check("nop_rf_we", 32'(bus.rf_we), 0);
    check("nop_dmem_we", 32'(bus.dmem_we), 0);
    step();
    check("wrap_pc", 32'(bus.pc), 0);
    exec_pc("nop_pc1", itype(6'h3F,1,2,16'h1234), 9, 9, 16'd1);

    // Reset asserted mid-program takes effect at the next edge.
    exec_pc("j_mid", itype(6'h02,0,0,16'd300), 0, 0, 16'd300);
    drive(add_r3, 7, 5, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_pc_hold", 32'(bus.pc), 300);
    check("mid_rst_rf_we", 32'(bus.rf_we), 0);
    step();
    check("mid_rst_pc", 32'(bus.pc), 0);
    rst = 1'b0;
    step();
    check("post_rst_pc", 32'(bus.pc), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
